// File: rtl/dct_sched.sv
`default_nettype none
// ============================================================================
//  Module      : dct_sched
//  Description : Round-robin scheduler that shares one free-running 8-point
//                1-D DCT core between two sample requesters. The core takes
//                one sample per cycle on an 8-phase counter and has no
//                handshake. This block keeps a phase counter in lockstep with
//                the core and grants whole 8-sample rounds. It steers the
//                granted requester onto the core input and tags every
//                returned coefficient with its owner and index.
//
//  Optional    : DCT_SCHED_SYNC_CHECK_EN
//                When defined, core_fin is compared against the expected
//                phase every cycle from the second round after reset, and
//                any mismatch sets the sticky sync_err flag. When undefined,
//                sync_err is tied low and core_fin is ignored.
//
//  Ports
//    clk        in   clock, shared with the core
//    rst        in   synchronous active-high reset (also resets the core)
//    req_valid  in   [1:0]  per-requester sample valid
//    req_data0  in   [W-1:0] requester 0 sample
//    req_data1  in   [W-1:0] requester 1 sample
//    req_ready  out  [1:0]  per-requester sample accept
//    core_in    out  [W-1:0] sample driven to the core
//    core_o     in   [W-1:0] coefficient returned by the core
//    core_fin   in   core finish flag (phase-sync check only)
//    out_valid  out  coefficient valid
//    out_data   out  [W-1:0] coefficient (straight from core_o)
//    out_id     out  owning requester of the coefficient
//    out_idx    out  [2:0] coefficient index 0..7
//    out_last   out  high with the index-7 coefficient
//    underrun   out  sticky: granted requester missed a sample
//    sync_err   out  sticky: core phase mismatch
//
//  Revision    : 1.0  initial release
// ============================================================================
module dct_sched #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    input  logic [W-1:0] req_data0,
    input  logic [W-1:0] req_data1,
    output logic [1:0]   req_ready,
    output logic [W-1:0] core_in,
    input  logic [W-1:0] core_o,
    input  logic         core_fin,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_id,
    output logic [2:0]   out_idx,
    output logic         out_last,
    output logic         underrun,
    output logic         sync_err
);

    // ------------------------------------------------------------------------
    // Phase constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_PHASE_FIRST = 3'd0;   // first sample of a round
    localparam logic [2:0] c_PHASE_LAST  = 3'd7;   // grant decision phase
    localparam logic [2:0] c_PHASE_FIN   = 3'd1;   // core raises core_fin here

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [2:0] r_phase;      // lockstep copy of the core's phase counter
    logic       r_last_gnt;   // requester granted most recently

    // Tag pipeline. Each tag is (valid, owner).
    //   fed    : round currently being fed into the core
    //   done   : round whose samples the core is now transforming
    //   result : round whose coefficients are now on core_o
    logic       r_fed_vld;
    logic       r_fed_id;
    logic       r_done_vld;
    logic       r_done_id;
    logic       r_res_vld;
    logic       r_res_id;

    logic       r_underrun;

    // ------------------------------------------------------------------------
    // Grant decision for the next round (used only at the phase-7 edge)
    // ------------------------------------------------------------------------
    logic       w_gnt_vld;
    logic       w_gnt_id;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = 1'b0;
        unique case (req_valid)
            2'b01: begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 1'b0;
            end
            2'b10: begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 1'b1;
            end
            2'b11: begin
                // Tie: the requester that did not win last time goes next.
                w_gnt_vld = 1'b1;
                w_gnt_id  = ~r_last_gnt;
            end
            default: begin
                w_gnt_vld = 1'b0;
                w_gnt_id  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Core input steering (from registered grant only, so req_ready has no
    // path from req_valid)
    // ------------------------------------------------------------------------
    logic         w_own_valid;   // granted requester is presenting a sample
    logic [W-1:0] w_own_data;

    assign w_own_valid = r_fed_vld & req_valid[r_fed_id];
    assign w_own_data  = r_fed_id ? req_data1 : req_data0;

    always_comb begin
        req_ready = 2'b00;
        if (r_fed_vld) begin
            req_ready = r_fed_id ? 2'b10 : 2'b01;
        end
    end

    // A granted requester that misses a slot injects zero into the core; the
    // round still runs to completion because the core cannot be stalled.
    assign core_in = w_own_valid ? w_own_data : '0;

    // ------------------------------------------------------------------------
    // Phase counter, tag pipeline and underrun flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase    <= c_PHASE_FIRST;
            r_last_gnt <= 1'b1;
            r_fed_vld  <= 1'b0;
            r_fed_id   <= 1'b0;
            r_done_vld <= 1'b0;
            r_done_id  <= 1'b0;
            r_res_vld  <= 1'b0;
            r_res_id   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_phase <= r_phase + 3'd1;

            if (r_phase == c_PHASE_LAST) begin
                // Round boundary: the round just fed moves to "done" and the
                // fresh grant becomes the round to feed next.
                r_done_vld <= r_fed_vld;
                r_done_id  <= r_fed_id;
                r_fed_vld  <= w_gnt_vld;
                r_fed_id   <= w_gnt_id;
                if (w_gnt_vld) begin
                    r_last_gnt <= w_gnt_id;
                end
            end

            // Coefficient 0 of a round appears one cycle after the following
            // round's phase-0 sample, so the result tag lags by one phase.
            if (r_phase == c_PHASE_FIRST) begin
                r_res_vld <= r_done_vld;
                r_res_id  <= r_done_id;
            end

            if (r_fed_vld && !req_valid[r_fed_id]) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign underrun = r_underrun;

    // ------------------------------------------------------------------------
    // Result tagging. While the result tag is live, phase p carries
    // coefficient p-1 (mod 8): phases 1..7 then 0 give indices 0..7.
    // ------------------------------------------------------------------------
    logic [2:0] w_res_idx;

    assign w_res_idx = r_phase - 3'd1;

    assign out_data  = core_o;
    assign out_valid = r_res_vld;
    assign out_id    = r_res_vld & r_res_id;
    assign out_idx   = r_res_vld ? w_res_idx : 3'd0;
    assign out_last  = r_res_vld & (r_phase == c_PHASE_FIRST);

    // ------------------------------------------------------------------------
    // Optional core phase-sync check
    // ------------------------------------------------------------------------
`ifdef DCT_SCHED_SYNC_CHECK_EN
    logic r_chk_en;     // set once round 0 is over; the core's first round
                        // after reset has no defined finish flag
    logic r_sync_err;
    logic w_fin_exp;

    assign w_fin_exp = (r_phase == c_PHASE_FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_en   <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            if (r_phase == c_PHASE_LAST) begin
                r_chk_en <= 1'b1;
            end
            if (r_chk_en && (core_fin != w_fin_exp)) begin
                r_sync_err <= 1'b1;
            end
        end
    end

    assign sync_err = r_sync_err;
`else
    logic w_unused_core_fin;

    assign w_unused_core_fin = core_fin;
    assign sync_err          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dct_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dct_sched
//  Description : Self-checking bench for dct_sched. Contains a behavioural
//                DCT core (integer cosine table, one-round latency) and a
//                round-level reference model of the scheduler that is
//                compared against the DUT every cycle, plus directed
//                literal checks at hand-computed cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dct_sched;

    localparam int W    = 25;
    localparam int MAXR = 64;
`ifdef DCT_SCHED_SYNC_CHECK_EN
    localparam bit SYNC_ON = 1'b1;
`else
    localparam bit SYNC_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_valid = 2'b00;
    logic [W-1:0] req_data0 = '0;
    logic [W-1:0] req_data1 = '0;
    logic [1:0]   req_ready;
    logic [W-1:0] core_in;
    logic [W-1:0] core_o;
    logic         core_fin;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_id;
    logic [2:0]   out_idx;
    logic         out_last;
    logic         underrun;
    logic         sync_err;

    always #5 clk = ~clk;

    dct_sched #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_ready (req_ready),
        .core_in   (core_in),
        .core_o    (core_o),
        .core_fin  (core_fin),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .underrun  (underrun),
        .sync_err  (sync_err)
    );

    // ------------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------------
    int ntests = 0;
    int nfail  = 0;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Integer 8-point DCT-II: coefficient k = sum x[n]*64*cos((2n+1)k*pi/16)
    // ------------------------------------------------------------------------
    function automatic int cosq(input int m_in);
        int m;
        int v;
        m = m_in % 32;
        if (m > 16) m = 32 - m;
        if (m > 8) m = 16 - m;
        case (m)
            0: v = 64;
            1: v = 63;
            2: v = 59;
            3: v = 53;
            4: v = 45;
            5: v = 36;
            6: v = 24;
            7: v = 12;
            default: v = 0;
        endcase
        if ((m_in % 32 > 8) && (m_in % 32 < 24)) v = -v;
        return v;
    endfunction

    function automatic int dct8(input int s[8], input int k);
        int acc;
        acc = 0;
        for (int n = 0; n < 8; n++) acc += s[n] * cosq((2 * n + 1) * k);
        return acc;
    endfunction

    // ------------------------------------------------------------------------
    // Behavioural core: free-running 8-phase, samples of a round are
    // transformed at its end and played out one per cycle starting one cycle
    // into the following round's phase 1.
    // ------------------------------------------------------------------------
    logic [2:0] cph;
    int         csamp [8];
    int         cbufA [8];
    int         cbufB [8];
    bit         fin_shift = 1'b0;

    always @(posedge clk) begin
        int s [8];
        if (rst) begin
            cph <= 3'd0;
            for (int k = 0; k < 8; k++) begin
                cbufA[k] <= 0;
                cbufB[k] <= 0;
                csamp[k] <= 0;
            end
        end else begin
            cph        <= cph + 3'd1;
            csamp[cph] <= int'($signed(core_in));
            if (cph == 3'd7) begin
                s    = csamp;
                s[7] = int'($signed(core_in));
                for (int k = 0; k < 8; k++) cbufA[k] <= dct8(s, k);
            end
            if (cph == 3'd0) cbufB <= cbufA;
        end
    end

    assign core_o   = W'(cbufB[cph - 3'd1]);
    assign core_fin = fin_shift ? (cph == 3'd2) : (cph == 3'd1);

    // ------------------------------------------------------------------------
    // Reference model: cycle t after reset lies in round t/8. own[r] is the
    // owner of round r (-1 idle), decided from req_valid at the last cycle of
    // round r-1. Coefficient i of round r appears at cycle 8r+9+i.
    // ------------------------------------------------------------------------
    int mt;
    int mlast;
    bit mund;
    bit msync;
    int own  [MAXR];
    int samp [MAXR][8];

    always @(negedge clk) begin
        int           r, p, r0, i, g;
        logic [1:0]   e_rdy;
        logic [W-1:0] e_in, e_data;
        logic         e_val, e_id, e_last;
        logic [2:0]   e_idx;
        int           s [8];
        if (rst) begin
            mt    = 0;
            mlast = 1;
            mund  = 1'b0;
            msync = 1'b0;
            for (int k = 0; k < MAXR; k++) own[k] = -1;
        end else if (mt / 8 + 1 < MAXR) begin
            r = mt / 8;
            p = mt % 8;
            g = own[r];
            e_rdy = 2'b00;
            e_in  = '0;
            if (g >= 0) begin
                e_rdy[g] = 1'b1;
                if (req_valid[g]) e_in = (g == 1) ? req_data1 : req_data0;
            end
            samp[r][p] = int'($signed(e_in));

            e_val  = 1'b0;
            e_id   = 1'b0;
            e_idx  = 3'd0;
            e_last = 1'b0;
            e_data = '0;
            if (mt >= 9) begin
                r0 = (mt - 9) / 8;
                i  = (mt - 9) % 8;
                if (own[r0] >= 0) begin
                    e_val  = 1'b1;
                    e_id   = own[r0][0];
                    e_idx  = i[2:0];
                    e_last = (i == 7);
                    for (int n = 0; n < 8; n++) s[n] = samp[r0][n];
                    e_data = W'(dct8(s, i));
                end
            end

            check("m_req_ready", req_ready, e_rdy);
            check("m_core_in",   core_in,   e_in);
            check("m_out_valid", out_valid, e_val);
            check("m_out_id",    out_id,    e_id);
            check("m_out_idx",   out_idx,   e_idx);
            check("m_out_last",  out_last,  e_last);
            check("m_underrun",  underrun,  mund);
            check("m_sync_err",  sync_err,  msync);
            if (e_val) check("m_out_data", out_data, e_data);

            if (g >= 0 && !req_valid[g]) mund = 1'b1;
            if (SYNC_ON && mt >= 8 && (core_fin != (p == 1))) msync = 1'b1;
            if (p == 7) begin
                if (req_valid == 2'b11)  own[r + 1] = 1 - mlast;
                else if (req_valid[0])   own[r + 1] = 0;
                else if (req_valid[1])   own[r + 1] = 1;
                else                     own[r + 1] = -1;
                if (own[r + 1] >= 0) mlast = own[r + 1];
            end
            mt++;
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    int dcyc = 0;

    task automatic step();
        @(posedge clk);
        #1;
        dcyc++;
    endtask

    task automatic goto_cyc(input int n);
        while (dcyc < n) step();
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        req_data0 = '0;
        req_data1 = '0;
        step();
        step();
        rst  = 1'b0;
        dcyc = 0;
    endtask

    initial begin
        // ---- single requester 0, eight samples of 10 ----
        do_reset();
        at_neg();
        check("t1_reset_ready", req_ready, 2'b00);
        check("t1_reset_valid", out_valid, 1'b0);
        req_valid = 2'b01;
        req_data0 = W'(10);
        goto_cyc(8);  at_neg();
        check("t1_ready_c8", req_ready, 2'b01);
        check("t1_core_in_c8", core_in, W'(10));
        goto_cyc(15); at_neg();
        check("t1_ready_c15", req_ready, 2'b01);
        goto_cyc(16);
        req_valid = 2'b00;
        req_data0 = '0;
        at_neg();
        check("t1_valid_c16", out_valid, 1'b0);
        goto_cyc(17); at_neg();
        check("t1_valid_c17", out_valid, 1'b1);
        check("t1_id_c17", out_id, 1'b0);
        check("t1_idx_c17", out_idx, 3'd0);
        check("t1_dc", out_data, W'(5120));
        check("t1_underrun_c17", underrun, 1'b1);
        goto_cyc(18); at_neg();
        check("t1_ac1", out_data, W'(0));
        check("t1_idx_c18", out_idx, 3'd1);
        goto_cyc(24); at_neg();
        check("t1_last_c24", out_last, 1'b1);
        check("t1_idx_c24", out_idx, 3'd7);
        goto_cyc(40);

        // ---- both requesters continuously: alternating grants ----
        do_reset();
        for (int c = 0; c < 56; c++) begin
            goto_cyc(c);
            req_valid = 2'b11;
            req_data0 = W'(3 * c + 1);
            req_data1 = W'(50 - 2 * c);
            if (c == 8)  begin at_neg(); check("t2_ready_r1", req_ready, 2'b01); end
            if (c == 16) begin at_neg(); check("t2_ready_r2", req_ready, 2'b10); end
            if (c == 24) begin at_neg(); check("t2_ready_r3", req_ready, 2'b01); end
            if (c == 17) begin at_neg(); check("t2_id_r1", out_id, 1'b0);
                                         check("t2_dc_r1", out_data, W'(18176)); end
            if (c == 25) begin at_neg(); check("t2_id_r2", out_id, 1'b1); end
            if (c == 33) begin at_neg(); check("t2_id_r3", out_id, 1'b0); end
        end
        goto_cyc(56);
        req_valid = 2'b00;
        goto_cyc(72);

        // ---- requester 0 drops one sample in phase 3 ----
        do_reset();
        req_valid = 2'b01;
        req_data0 = W'(-7);
        goto_cyc(11);
        req_valid = 2'b00;
        at_neg();
        check("t3_core_in_gap", core_in, W'(0));
        check("t3_underrun_before", underrun, 1'b0);
        goto_cyc(12);
        req_valid = 2'b01;
        at_neg();
        check("t3_underrun_after", underrun, 1'b1);
        goto_cyc(16);
        req_valid = 2'b00;
        goto_cyc(17); at_neg();
        check("t3_valid", out_valid, 1'b1);
        check("t3_dc", out_data, W'(-3136));
        goto_cyc(40); at_neg();
        check("t3_underrun_sticky", underrun, 1'b1);

        // ---- no requests for several rounds ----
        do_reset();
        req_data0 = W'(5);
        req_data1 = W'(9);
        goto_cyc(20); at_neg();
        check("t4_valid", out_valid, 1'b0);
        check("t4_core_in", core_in, W'(0));
        goto_cyc(32); at_neg();
        check("t4_ready", req_ready, 2'b00);

        // ---- reset in phase 4 of a granted round ----
        do_reset();
        req_valid = 2'b10;
        req_data1 = W'(20);
        goto_cyc(10);
        req_valid = 2'b00;
        goto_cyc(11); at_neg();
        check("t5_underrun_pre", underrun, 1'b1);
        check("t5_ready_pre", req_ready, 2'b10);
        goto_cyc(12);
        rst = 1'b1;
        step();
        rst  = 1'b0;
        dcyc = 0;
        at_neg();
        check("t5_rst_ready", req_ready, 2'b00);
        check("t5_rst_core_in", core_in, W'(0));
        check("t5_rst_valid", out_valid, 1'b0);
        check("t5_rst_id", out_id, 1'b0);
        check("t5_rst_idx", out_idx, 3'd0);
        check("t5_rst_last", out_last, 1'b0);
        check("t5_rst_underrun", underrun, 1'b0);
        check("t5_rst_sync", sync_err, 1'b0);
        goto_cyc(17); at_neg();
        check("t5_no_valid", out_valid, 1'b0);
        goto_cyc(30);

        // ---- core finish flag shifted by one cycle ----
        fin_shift = 1'b1;
        do_reset();
        goto_cyc(7); at_neg();
        check("t6_sync_round0", sync_err, 1'b0);
        goto_cyc(15); at_neg();
        check("t6_sync_round1", sync_err, SYNC_ON ? 1'b1 : 1'b0);
        fin_shift = 1'b0;
        do_reset();
        goto_cyc(20); at_neg();
        check("t6_sync_aligned", sync_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
